matrix_engine_param: RTL and testbench
======================================

Name: matrix_engine_param

Overview:
Parametrised successor to the team's fixed 5x5/8-bit matrix calculator. It handles transpose, add, subtract, scalar multiply, Hadamard product and matrix multiply on matrices up to MAX_DIM x MAX_DIM with DATA_W-bit unsigned elements. All operands are captured when start is accepted, so the host can change its inputs while the block is busy. A busy/done handshake and an encoded error status are provided. The block sits behind the host command decoder as the compute core.

Parameters:
DATA_W, 8, element width of A, B and scalar (unsigned)
MAX_DIM, 5, maximum rows/cols of any operand (2..7)
DIM_W, 3, width of each dimension field; must hold MAX_DIM
RES_W, 20, result element width; must be at least 2*DATA_W + clog2(MAX_DIM)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  0 transpose, 1 add, 2 scalar mul, 3 matmul, 4 subtract (A-B), 5 Hadamard; 6-7 illegal
a_rows, a_cols, b_rows, b_cols  in  DIM_W each  operand dimensions
scalar  in  DATA_W  scalar for op 2
a_data, b_data  in  MAX_DIM*MAX_DIM*DATA_W  row-major; element i at [i*DATA_W +: DATA_W]
result_data  out  MAX_DIM*MAX_DIM*RES_W  row-major; element i at [i*RES_W +: RES_W]
res_rows, res_cols  out  DIM_W each  result dimensions
busy  out  1  high while not IDLE
done  out  1  one-cycle completion pulse
error  out  1  valid with done
err_code  out  2  0 none, 1 illegal op, 2 A dimension zero or >MAX_DIM, 3 B invalid or B incompatible with A

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; busy=0, done=0, error=0, err_code=0, res_rows=0, res_cols=0, result_data=0; internal element and accumulator storage cleared.
- States: IDLE, CHECK, CALC, FINISH.
- IDLE:
  - done deasserts after one cycle.
  - On start=1, capture op, all dims, scalar, a_data and b_data into registers, then go to CHECK.
  - err_code and error hold their last values until the next accept. On the accept edge they clear to 0.
- CHECK (1 cycle), validation in priority order:
  - Illegal op gives code 1.
  - a_rows or a_cols equal to 0 or greater than MAX_DIM gives code 2.
  - For ops 1, 4 and 5, B dims must equal A dims, otherwise code 3.
  - For op 3, b_rows must equal a_cols and b_cols must be in 1..MAX_DIM, otherwise code 3.
  - On error, go to FINISH with the error flag set. Otherwise clear the result store and go to CALC.
- CALC, one step per cycle:
  - Elementwise ops and transpose: N = a_rows*a_cols steps, row-major over A.
  - Transpose writes res[c*a_rows+r] = A[r][c].
  - Matmul: N = a_rows*b_cols*a_cols steps, one MAC per cycle with k innermost. The accumulator adds A[r][k]*B[k][c]. On k = a_cols-1 the final sum (including that product) is written to res[r*b_cols+c] and the accumulator clears. No extra idle cycle per element.
  - Go to FINISH on the last step.
- Arithmetic:
  - All operands zero-extended to RES_W.
  - Subtract produces a RES_W-bit two's-complement result.
  - Other ops cannot overflow given the RES_W rule. Results wrap modulo 2^RES_W.
- FINISH (1 cycle):
  - Drive result_data from the result store. Entries outside res_rows x res_cols are 0.
  - Set res_rows/res_cols: transpose gives (a_cols,a_rows); matmul gives (a_rows,b_cols); all others give (a_rows,a_cols).
  - Pulse done=1, go to IDLE.
  - On error: result_data, res_rows and res_cols keep their previous values; error=1 and err_code are set.
- Latency:
  - Counting the accept edge as edge 1, done is high after edge N+3 on success and after edge 3 on error.
  - busy is high from after edge 1 through the FINISH cycle and falls on the same edge done rises.
- start while busy is ignored, with no queuing. start held high in IDLE the cycle after done starts a new operation.
- Input changes after the accept edge have no effect.
- Reset asserted mid-operation aborts immediately to reset values with no done pulse.

Test Plan:
- Matmul: A=[1 2 3;4 5 6] (2x3), B=[7 8;9 10;11 12] (3x2), op=3 -> res=[58 64;139 154], dims 2x2, N=12, done after edge 15, error=0.
- Transpose of the same 2x3 A, op=0 -> res=[1 4;2 5;3 6], dims 3x2, elements 6..24 zero, done after edge 9.
- Subtract 1x1: A=3, B=5, op=4 -> res[0]=0xFFFFE (RES_W=20). Scalar mul: A=255, scalar=255, op=2 -> 65025.
- Errors:
  - op=7 -> done after edge 3, error=1, err_code=1, previous result_data unchanged.
  - Add with A 2x2 and B 2x3 -> err_code=3.
  - a_rows=6 -> err_code=2.
- Handshake: pulse start again and change a_data mid-CALC -> second start ignored and result reflects the captured data. Assert rst_n=0 mid-CALC -> all outputs 0 and no done.
- Max size: 5x5 by 5x5 matmul with all elements 255 -> every element 325125, done after edge 128.

Source files
------------

// File: rtl/matrix_engine_param.sv
// matrix_engine_param
// Parametrised matrix compute core: transpose, add, subtract, scalar multiply,
// Hadamard product and matrix multiply on matrices up to MAX_DIM x MAX_DIM.
// Operands are captured on the accepted start so the host may change its
// inputs while the engine is busy. Results are published only in FINISH,
// so a failed request leaves the previous result visible.
module matrix_engine_param #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3,
  parameter int RES_W   = 20
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [2:0]                         op,
  input  logic [DIM_W-1:0]                   a_rows,
  input  logic [DIM_W-1:0]                   a_cols,
  input  logic [DIM_W-1:0]                   b_rows,
  input  logic [DIM_W-1:0]                   b_cols,
  input  logic [DATA_W-1:0]                  scalar,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  a_data,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  b_data,
  output logic [MAX_DIM*MAX_DIM*RES_W-1:0]   result_data,
  output logic [DIM_W-1:0]                   res_rows,
  output logic [DIM_W-1:0]                   res_cols,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [1:0]                         err_code
);

  localparam int NE     = MAX_DIM * MAX_DIM;
  localparam int PROD_W = 2 * DIM_W;
  localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE_V     = DIM_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [2:0] OP_TRN = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SCL = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_HAD = 3'd5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OP   = 2'd1;
  localparam logic [1:0] ERR_A    = 2'd2;
  localparam logic [1:0] ERR_B    = 2'd3;

  // Control and captured-operand registers
  logic [1:0]             state_r;
  logic [2:0]             op_r;
  logic [DIM_W-1:0]       a_rows_r;
  logic [DIM_W-1:0]       a_cols_r;
  logic [DIM_W-1:0]       b_rows_r;
  logic [DIM_W-1:0]       b_cols_r;
  logic [DATA_W-1:0]      scalar_r;
  logic [NE*DATA_W-1:0]   a_flat_r;
  logic [NE*DATA_W-1:0]   b_flat_r;
  logic [1:0]             err_pend_r;

  // Datapath registers
  logic [NE*RES_W-1:0]    res_flat_r;
  logic [RES_W-1:0]       acc_r;
  logic [DIM_W-1:0]       row_r;
  logic [DIM_W-1:0]       col_r;
  logic [DIM_W-1:0]       k_r;

  // Output registers
  logic [NE*RES_W-1:0]    result_r;
  logic [DIM_W-1:0]       res_rows_r;
  logic [DIM_W-1:0]       res_cols_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   error_r;
  logic [1:0]             err_code_r;

  // Combinational helpers
  logic                   accept_s;
  logic                   is_mm_s;
  logic                   a_dims_ok_s;
  logic                   b_same_s;
  logic                   b_mm_ok_s;
  logic [1:0]             check_code_s;
  logic [DIM_W-1:0]       inner_col_s;
  logic [DIM_W-1:0]       col_limit_s;
  logic [PROD_W-1:0]      a_lin_s;
  logic [PROD_W-1:0]      b_lin_s;
  logic [PROD_W-1:0]      res_lin_s;
  logic [DATA_W-1:0]      a_el_s;
  logic [DATA_W-1:0]      b_el_s;
  logic [RES_W-1:0]       a_ext_s;
  logic [RES_W-1:0]       b_ext_s;
  logic [RES_W-1:0]       s_ext_s;
  logic [RES_W-1:0]       prod_s;
  logic [RES_W-1:0]       elem_val_s;
  logic                   last_k_s;
  logic                   last_c_s;
  logic                   last_r_s;

  assign result_data = result_r;
  assign res_rows    = res_rows_r;
  assign res_cols    = res_cols_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign err_code    = err_code_r;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign is_mm_s  = (op_r == OP_MUL);

  // Validate the captured request; earlier checks take priority
  always_comb begin
    a_dims_ok_s  = (a_rows_r != '0) && (a_rows_r <= MAX_DIM_V) &&
                   (a_cols_r != '0) && (a_cols_r <= MAX_DIM_V);
    b_same_s     = (b_rows_r == a_rows_r) && (b_cols_r == a_cols_r);
    b_mm_ok_s    = (b_rows_r == a_cols_r) && (b_cols_r != '0) &&
                   (b_cols_r <= MAX_DIM_V);
    check_code_s = ERR_NONE;
    if (op_r > OP_HAD) begin
      check_code_s = ERR_OP;
    end else if (!a_dims_ok_s) begin
      check_code_s = ERR_A;
    end else if (((op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_HAD)) && !b_same_s) begin
      check_code_s = ERR_B;
    end else if (is_mm_s && !b_mm_ok_s) begin
      check_code_s = ERR_B;
    end else begin
      check_code_s = ERR_NONE;
    end
  end

  // Element addressing for the current step (k innermost for matmul)
  always_comb begin
    inner_col_s = is_mm_s ? k_r : col_r;
    col_limit_s = is_mm_s ? b_cols_r : a_cols_r;
    a_lin_s = PROD_W'(row_r) * PROD_W'(a_cols_r) + PROD_W'(inner_col_s);
    if (is_mm_s) begin
      b_lin_s   = PROD_W'(k_r) * PROD_W'(b_cols_r) + PROD_W'(col_r);
      res_lin_s = PROD_W'(row_r) * PROD_W'(b_cols_r) + PROD_W'(col_r);
    end else if (op_r == OP_TRN) begin
      b_lin_s   = a_lin_s;
      res_lin_s = PROD_W'(col_r) * PROD_W'(a_rows_r) + PROD_W'(row_r);
    end else begin
      b_lin_s   = a_lin_s;
      res_lin_s = a_lin_s;
    end
    last_k_s = (k_r == (a_cols_r - ONE_V));
    last_c_s = (col_r == (col_limit_s - ONE_V));
    last_r_s = (row_r == (a_rows_r - ONE_V));
  end

  // Per-step arithmetic on zero-extended operands, wrapping at RES_W
  always_comb begin
    a_el_s  = a_flat_r[a_lin_s*DATA_W +: DATA_W];
    b_el_s  = b_flat_r[b_lin_s*DATA_W +: DATA_W];
    a_ext_s = RES_W'(a_el_s);
    b_ext_s = RES_W'(b_el_s);
    s_ext_s = RES_W'(scalar_r);
    prod_s  = a_ext_s * b_ext_s;
    case (op_r)
      OP_TRN:  elem_val_s = a_ext_s;
      OP_ADD:  elem_val_s = a_ext_s + b_ext_s;
      OP_SCL:  elem_val_s = a_ext_s * s_ext_s;
      OP_MUL:  elem_val_s = acc_r + prod_s;
      OP_SUB:  elem_val_s = a_ext_s - b_ext_s;
      OP_HAD:  elem_val_s = prod_s;
      default: elem_val_s = '0;
    endcase
  end

  // Sequencer: IDLE -> CHECK -> (CALC) -> FINISH -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      err_pend_r <= ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_CHECK;
            err_pend_r <= ERR_NONE;
          end
        end
        ST_CHECK: begin
          err_pend_r <= check_code_s;
          state_r    <= (check_code_s != ERR_NONE) ? ST_FINISH : ST_CALC;
        end
        ST_CALC: begin
          if ((!is_mm_s || last_k_s) && last_c_s && last_r_s) begin
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand capture on the accepted start only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 3'd0;
      a_rows_r <= '0;
      a_cols_r <= '0;
      b_rows_r <= '0;
      b_cols_r <= '0;
      scalar_r <= '0;
      a_flat_r <= '0;
      b_flat_r <= '0;
    end else if (accept_s) begin
      op_r     <= op;
      a_rows_r <= a_rows;
      a_cols_r <= a_cols;
      b_rows_r <= b_rows;
      b_cols_r <= b_cols;
      scalar_r <= scalar;
      a_flat_r <= a_data;
      b_flat_r <= b_data;
    end
  end

  // Step counters, accumulator and result store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_flat_r <= '0;
      acc_r      <= '0;
      row_r      <= '0;
      col_r      <= '0;
      k_r        <= '0;
    end else if ((state_r == ST_CHECK) && (check_code_s == ERR_NONE)) begin
      res_flat_r <= '0;
      acc_r      <= '0;
      row_r      <= '0;
      col_r      <= '0;
      k_r        <= '0;
    end else if (state_r == ST_CALC) begin
      if (is_mm_s && !last_k_s) begin
        acc_r <= elem_val_s;
        k_r   <= k_r + ONE_V;
      end else begin
        res_flat_r[res_lin_s*RES_W +: RES_W] <= elem_val_s;
        acc_r <= '0;
        k_r   <= '0;
        if (last_c_s) begin
          col_r <= '0;
          row_r <= last_r_s ? row_r : row_r + ONE_V;
        end else begin
          col_r <= col_r + ONE_V;
        end
      end
    end
  end

  // Handshake and published results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
      result_r   <= '0;
      res_rows_r <= '0;
      res_cols_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            busy_r     <= 1'b1;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
          end
        end
        ST_FINISH: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (err_pend_r != ERR_NONE) begin
            error_r    <= 1'b1;
            err_code_r <= err_pend_r;
          end else begin
            result_r <= res_flat_r;
            if (op_r == OP_TRN) begin
              res_rows_r <= a_cols_r;
              res_cols_r <= a_rows_r;
            end else if (is_mm_s) begin
              res_rows_r <= a_rows_r;
              res_cols_r <= b_cols_r;
            end else begin
              res_rows_r <= a_rows_r;
              res_cols_r <= a_cols_r;
            end
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_engine_param.sv
// Directed bench for matrix_engine_param with hand-computed expectations.
module tb_matrix_engine_param;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int DIM_W   = 3;
  localparam int RES_W   = 20;
  localparam int NE      = MAX_DIM * MAX_DIM;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [2:0]            op = 3'd0;
  logic [DIM_W-1:0]      a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic [DATA_W-1:0]     scalar = '0;
  logic [NE*DATA_W-1:0]  a_data = '0, b_data = '0;
  logic [NE*RES_W-1:0]   result_data;
  logic [DIM_W-1:0]      res_rows, res_cols;
  logic                  busy, done, error;
  logic [1:0]            err_code;

  int n_assert = 0;
  int n_fail   = 0;

  matrix_engine_param #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .scalar(scalar), .a_data(a_data), .b_data(b_data),
    .result_data(result_data), .res_rows(res_rows), .res_cols(res_cols),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rel(input int i);
    return 32'(result_data[i*RES_W +: RES_W]);
  endfunction

  task automatic set_a(input int i, input int v);
    a_data[i*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  task automatic set_b(input int i, input int v);
    b_data[i*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  // Present a request and take the accept edge (edge 1)
  task automatic issue(input logic [2:0] o, input int ar, input int ac, input int br, input int bc);
    op = o;
    a_rows = DIM_W'(ar); a_cols = DIM_W'(ac);
    b_rows = DIM_W'(br); b_cols = DIM_W'(bc);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Count edges until done, bounded; checks the edge done appears after
  task automatic wait_done(input string tag, input int from_edge, input int exp_edge);
    int e;
    bit seen;
    e = from_edge;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      e++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_edge"}, seen ? 32'(e) : 32'hFFFF_FFFF, 32'(exp_edge));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_dims", {16'(res_rows), 16'(res_cols)}, 32'd0);
    chk("rst_result_zero", 32'(result_data == '0), 32'd1);
    rst_n = 1'b1;
    step();

    // Matmul 2x3 * 3x2, with a second start and new A data mid-CALC
    for (int i = 0; i < 6; i++) begin
      set_a(i, i + 1);
      set_b(i, i + 7);
    end
    issue(3'd3, 2, 3, 3, 2);
    for (int i = 0; i < 4; i++) step();
    start = 1'b1;
    a_data = '1;
    step();
    start = 1'b0;
    wait_done("mm", 6, 15);
    chk("mm_r0", rel(0), 32'd58);
    chk("mm_r1", rel(1), 32'd64);
    chk("mm_r2", rel(2), 32'd139);
    chk("mm_r3", rel(3), 32'd154);
    chk("mm_r4_zero", rel(4), 32'd0);
    chk("mm_dims", {16'(res_rows), 16'(res_cols)}, {16'd2, 16'd2});
    chk("mm_error", 32'(error), 32'd0);
    step();
    chk("mm_done_falls", 32'(done), 32'd0);

    // Transpose of the same 2x3 A
    a_data = '0;
    for (int i = 0; i < 6; i++) set_a(i, i + 1);
    issue(3'd0, 2, 3, 0, 0);
    wait_done("trn", 1, 9);
    chk("trn_r0", rel(0), 32'd1);
    chk("trn_r1", rel(1), 32'd4);
    chk("trn_r2", rel(2), 32'd2);
    chk("trn_r3", rel(3), 32'd5);
    chk("trn_r4", rel(4), 32'd3);
    chk("trn_r5", rel(5), 32'd6);
    chk("trn_r6_zero", rel(6), 32'd0);
    chk("trn_r24_zero", rel(24), 32'd0);
    chk("trn_dims", {16'(res_rows), 16'(res_cols)}, {16'd3, 16'd2});

    // Illegal op: previous result must survive
    issue(3'd7, 2, 3, 2, 3);
    wait_done("ill", 1, 3);
    chk("ill_error", 32'(error), 32'd1);
    chk("ill_code", 32'(err_code), 32'd1);
    chk("ill_keep_r1", rel(1), 32'd4);
    chk("ill_keep_dims", {16'(res_rows), 16'(res_cols)}, {16'd3, 16'd2});

    // Subtract 1x1 wraps to two's complement
    a_data = '0; b_data = '0;
    set_a(0, 3); set_b(0, 5);
    issue(3'd4, 1, 1, 1, 1);
    wait_done("sub", 1, 4);
    chk("sub_r0", rel(0), 32'h000F_FFFE);
    chk("sub_error_cleared", 32'(error), 32'd0);
    chk("sub_code_cleared", 32'(err_code), 32'd0);
    chk("sub_r1_cleared", rel(1), 32'd0);
    chk("sub_dims", {16'(res_rows), 16'(res_cols)}, {16'd1, 16'd1});

    // Scalar multiply 255*255
    set_a(0, 255);
    scalar = 8'd255;
    issue(3'd2, 1, 1, 0, 0);
    wait_done("scl", 1, 4);
    chk("scl_r0", rel(0), 32'd65025);

    // Add with mismatched B
    issue(3'd1, 2, 2, 2, 3);
    wait_done("badb", 1, 3);
    chk("badb_code", 32'(err_code), 32'd3);

    // A rows above MAX_DIM
    issue(3'd1, 6, 2, 6, 2);
    wait_done("bada", 1, 3);
    chk("bada_code", 32'(err_code), 32'd2);
    chk("bada_error", 32'(error), 32'd1);

    // Add and Hadamard on 2x2
    a_data = '0; b_data = '0;
    for (int i = 0; i < 4; i++) begin
      set_a(i, i + 1);
      set_b(i, i + 5);
    end
    issue(3'd1, 2, 2, 2, 2);
    wait_done("add", 1, 7);
    chk("add_r0", rel(0), 32'd6);
    chk("add_r3", rel(3), 32'd12);
    issue(3'd5, 2, 2, 2, 2);
    wait_done("had", 1, 7);
    chk("had_r1", rel(1), 32'd12);
    chk("had_r2", rel(2), 32'd21);
    chk("had_r3", rel(3), 32'd32);

    // Max-size matmul, all elements 255
    a_data = '1; b_data = '1;
    issue(3'd3, 5, 5, 5, 5);
    wait_done("max", 1, 128);
    chk("max_r0", rel(0), 32'd325125);
    chk("max_r12", rel(12), 32'd325125);
    chk("max_r24", rel(24), 32'd325125);
    chk("max_dims", {16'(res_rows), 16'(res_cols)}, {16'd5, 16'd5});

    // Reset mid-CALC aborts with no done
    issue(3'd3, 5, 5, 5, 5);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result_zero", 32'(result_data == '0), 32'd1);
    chk("abort_dims", {16'(res_rows), 16'(res_cols)}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_stay_idle", {16'(busy), 16'(done)}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
